// File: rtl/score_keeper.sv
// Score producer: counts goals, detects the match win and drives
// tear-free 3x5 digit bitmaps with a blinking winner glyph.
package score_pkg;
  localparam int SCORE_W = 3;
  localparam int SCORE_H = 5;
  typedef logic [SCORE_H-1:0][SCORE_W-1:0] score_t;
endpackage

module score_keeper
  import score_pkg::*;
#(
  parameter int WIN_SCORE    = 5,
  parameter int HOLD_FRAMES  = 180,
  parameter int BLINK_FRAMES = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       goal_p_i,
  input  logic       goal_e_i,
  input  logic       frame_tick_i,
  input  logic       restart_i,
  output score_t     player_score_o,
  output score_t     enemy_score_o,
  output logic [3:0] player_cnt_o,
  output logic [3:0] enemy_cnt_o,
  output logic       game_over_o,
  output logic       winner_o
);

  if (SCORE_W != 3 || SCORE_H != 5) begin : g_bad_font
    $error("score_pkg must define a 3x5 glyph");
  end

  localparam int FW = (HOLD_FRAMES > 0) ?
                      $clog2(HOLD_FRAMES + 1) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [3:0]    WIN   = 4'(WIN_SCORE);
  localparam logic [FW-1:0] HOLD  = FW'(HOLD_FRAMES);
  localparam logic [BW-1:0] BLINK = BW'(BLINK_FRAMES);
  localparam bit            HOLD_EN = HOLD_FRAMES > 0;

  typedef enum logic {
    PLAY,
    GAME_OVER
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    pcnt_q, pcnt_d;
  logic [3:0]    ecnt_q, ecnt_d;
  logic          win_q, win_d;
  logic          gp_q, ge_q;
  logic [FW-1:0] frame_q, frame_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          hide_q, hide_d;
  score_t        pbm_q, pbm_d;
  score_t        ebm_q, ebm_d;

  logic          p_edge, e_edge;
  logic [3:0]    p_inc, e_inc;
  logic [FW-1:0] frame_inc;
  logic [BW-1:0] blink_inc;
  logic          leave;

  // Rows are written top to bottom, each row left to right.
  function automatic score_t glyph(input logic [3:0] d);
    logic [14:0] v;
    score_t      g;
    case (d)
      4'd0:    v = 15'b111_101_101_101_111;
      4'd1:    v = 15'b001_001_001_001_001;
      4'd2:    v = 15'b111_001_111_100_111;
      4'd3:    v = 15'b111_001_111_001_111;
      4'd4:    v = 15'b101_101_111_001_001;
      4'd5:    v = 15'b111_100_111_001_111;
      4'd6:    v = 15'b111_100_111_101_111;
      4'd7:    v = 15'b111_001_001_001_001;
      4'd8:    v = 15'b111_101_111_101_111;
      4'd9:    v = 15'b111_101_111_001_111;
      default: v = 15'b111_101_101_101_111;
    endcase
    for (int r = 0; r < SCORE_H; r++)
      for (int c = 0; c < SCORE_W; c++)
        g[r][c] = v[14 - 3*r - c];
    return g;
  endfunction

  assign p_edge    = goal_p_i & ~gp_q;
  assign e_edge    = goal_e_i & ~ge_q;
  assign p_inc     = pcnt_q + {3'b000, p_edge};
  assign e_inc     = ecnt_q + {3'b000, e_edge};
  assign frame_inc = frame_q + 1'b1;
  assign blink_inc = blink_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    ecnt_d  = ecnt_q;
    win_d   = win_q;
    frame_d = frame_q;
    blink_d = blink_q;
    hide_d  = hide_q;
    pbm_d   = pbm_q;
    ebm_d   = ebm_q;
    leave   = 1'b0;

    unique case (state_q)
      PLAY: begin
        if (restart_i) begin
          pcnt_d = '0;
          ecnt_d = '0;
        end else begin
          pcnt_d = p_inc;
          ecnt_d = e_inc;
          if (p_inc == WIN || e_inc == WIN) begin
            state_d = GAME_OVER;
            win_d   = (p_inc == WIN);
          end
        end
      end
      GAME_OVER: begin
        if (restart_i) begin
          leave = 1'b1;
        end else if (frame_tick_i) begin
          frame_d = frame_inc;
          if (HOLD_EN && frame_inc == HOLD) begin
            leave = 1'b1;
          end else if (blink_inc == BLINK) begin
            blink_d = '0;
            hide_d  = ~hide_q;
          end else begin
            blink_d = blink_inc;
          end
        end
      end
      default: state_d = PLAY;
    endcase

    if (leave) begin
      state_d = PLAY;
      pcnt_d  = '0;
      ecnt_d  = '0;
      win_d   = 1'b0;
      frame_d = '0;
      blink_d = '0;
      hide_d  = 1'b0;
    end

    // Glyphs follow the pre-edge state so a frame never tears.
    if (frame_tick_i) begin
      pbm_d = glyph(pcnt_q);
      ebm_d = glyph(ecnt_q);
      if (state_q == GAME_OVER && hide_q) begin
        if (win_q) pbm_d = '0;
        else       ebm_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PLAY;
      pcnt_q  <= '0;
      ecnt_q  <= '0;
      win_q   <= 1'b0;
      gp_q    <= 1'b0;
      ge_q    <= 1'b0;
      frame_q <= '0;
      blink_q <= '0;
      hide_q  <= 1'b0;
      pbm_q   <= glyph(4'd0);
      ebm_q   <= glyph(4'd0);
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      ecnt_q  <= ecnt_d;
      win_q   <= win_d;
      gp_q    <= goal_p_i;
      ge_q    <= goal_e_i;
      frame_q <= frame_d;
      blink_q <= blink_d;
      hide_q  <= hide_d;
      pbm_q   <= pbm_d;
      ebm_q   <= ebm_d;
    end
  end

  assign player_score_o = pbm_q;
  assign enemy_score_o  = ebm_q;
  assign player_cnt_o   = pcnt_q;
  assign enemy_cnt_o    = ecnt_q;
  assign game_over_o    = (state_q == GAME_OVER);
  assign winner_o       = win_q;

endmodule

// File: tb/tb_score_keeper.sv
// Randomized and directed checks of score_keeper against a
// frame-level behavioural model of the scoreboard.
module tb_score_keeper;
  import score_pkg::*;

  localparam int WIN   = 5;
  localparam int HOLD  = 4;
  localparam int BLINK = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       goal_p = 1'b0;
  logic       goal_e = 1'b0;
  logic       tick = 1'b0;
  logic       restart = 1'b0;
  score_t     pbm, ebm;
  logic [3:0] pcnt, ecnt;
  logic       over, winner;

  int ncmp = 0;
  int nfail = 0;

  // Model state: plain integers, game time measured in frames.
  int     m_pc, m_ec, m_frames;
  bit     m_over, m_win, m_gp, m_ge;
  score_t m_pbm, m_ebm;

  always #5 clk = ~clk;

  score_keeper #(
    .WIN_SCORE(WIN),
    .HOLD_FRAMES(HOLD),
    .BLINK_FRAMES(BLINK)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .goal_p_i(goal_p),
    .goal_e_i(goal_e),
    .frame_tick_i(tick),
    .restart_i(restart),
    .player_score_o(pbm),
    .enemy_score_o(ebm),
    .player_cnt_o(pcnt),
    .enemy_cnt_o(ecnt),
    .game_over_o(over),
    .winner_o(winner)
  );

  logic [39:0] obs;
  assign obs = {pcnt, ecnt, over, winner, pbm, ebm};

  // Digit pictures: five rows of "###"-style strings, top first.
  function automatic score_t font(input int d);
    string rows[10][5];
    score_t g;
    rows[0] = '{"###", "#.#", "#.#", "#.#", "###"};
    rows[1] = '{"..#", "..#", "..#", "..#", "..#"};
    rows[2] = '{"###", "..#", "###", "#..", "###"};
    rows[3] = '{"###", "..#", "###", "..#", "###"};
    rows[4] = '{"#.#", "#.#", "###", "..#", "..#"};
    rows[5] = '{"###", "#..", "###", "..#", "###"};
    rows[6] = '{"###", "#..", "###", "#.#", "###"};
    rows[7] = '{"###", "..#", "..#", "..#", "..#"};
    rows[8] = '{"###", "#.#", "###", "#.#", "###"};
    rows[9] = '{"###", "#.#", "###", "..#", "###"};
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 3; c++)
        g[r][c] = (rows[d][r][c] == "#");
    return g;
  endfunction

  function automatic logic [39:0] exp_v();
    return {4'(m_pc), 4'(m_ec), m_over, m_win, m_pbm, m_ebm};
  endfunction

  task automatic m_reset();
    m_pc = 0; m_ec = 0; m_frames = 0;
    m_over = 0; m_win = 0; m_gp = 0; m_ge = 0;
    m_pbm = font(0); m_ebm = font(0);
  endtask

  task automatic m_leave();
    m_pc = 0; m_ec = 0; m_frames = 0;
    m_over = 0; m_win = 0;
  endtask

  // Drive one cycle, then advance the model by the same clock edge.
  task automatic step(input bit gp, input bit ge,
                      input bit tk, input bit rs);
    bit pe, ee, hid;
    goal_p = gp; goal_e = ge; tick = tk; restart = rs;
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else begin
      hid = ((m_frames / BLINK) % 2) == 1;
      if (tk) begin
        m_pbm = (m_over && m_win && hid) ? '0 : font(m_pc);
        m_ebm = (m_over && !m_win && hid) ? '0 : font(m_ec);
      end
      pe = gp && !m_gp; ee = ge && !m_ge;
      m_gp = gp; m_ge = ge;
      if (!m_over) begin
        if (rs) begin
          m_pc = 0; m_ec = 0;
        end else begin
          m_pc += int'(pe); m_ec += int'(ee);
          if (m_pc == WIN || m_ec == WIN) begin
            m_over = 1;
            m_win = (m_pc == WIN);
          end
        end
      end else if (rs) begin
        m_leave();
      end else if (tk) begin
        m_frames++;
        if (HOLD > 0 && m_frames == HOLD) m_leave();
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0);
    ncmp++;
    if (obs !== exp_v()) begin
      nfail++;
      $display("FAIL reset_hold got %h want %h", obs, exp_v());
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      ncmp++;
      if (obs !== exp_v()) begin
        nfail++;
        $display("FAIL reset_tick%0d got %h want %h", i, obs, exp_v());
      end
    end
  endtask

  task automatic test_single_goal();
    for (int i = 0; i < 60; i++) begin
      step(i == 10, 0, i == 50, 0);
      ncmp++;
      if (obs !== exp_v()) begin
        nfail++;
        $display("FAIL single_goal c%0d got %h want %h", i, obs, exp_v());
      end
    end
    ncmp++;
    if (pbm !== font(1)) begin
      nfail++;
      $display("FAIL single_glyph got %h want %h", pbm, font(1));
    end
  endtask

  task automatic test_held_level();
    for (int i = 0; i < 22; i++) begin
      step(0, i < 20, i == 21, 0);
      ncmp++;
      if (obs !== exp_v()) begin
        nfail++;
        $display("FAIL held_level c%0d got %h want %h", i, obs, exp_v());
      end
    end
    ncmp++;
    if (ecnt !== 4'd1) begin
      nfail++;
      $display("FAIL held_count got %0d want 1", ecnt);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) begin
      step(i == 1, i == 1, i == 3, 0);
      ncmp++;
      if (obs !== exp_v()) begin
        nfail++;
        $display("FAIL simul c%0d got %h want %h", i, obs, exp_v());
      end
    end
  endtask

  task automatic test_win_blink_hold();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      step(i % 2 == 0, 0, 0, 0);
      ncmp++;
      if (obs !== exp_v()) begin
        nfail++;
        $display("FAIL win c%0d got %h want %h", i, obs, exp_v());
      end
    end
    ncmp++;
    if ({over, winner, pcnt} !== {1'b1, 1'b1, 4'd5}) begin
      nfail++;
      $display("FAIL win_flags got %b%b/%0d want 11/5", over, winner, pcnt);
    end
    for (int i = 0; i < 15; i++) begin
      step(0, i == 1, i % 3 == 2, 0);
      ncmp++;
      if (obs !== exp_v()) begin
        nfail++;
        $display("FAIL blink c%0d got %h want %h", i, obs, exp_v());
      end
    end
  endtask

  task automatic test_tie_restart();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      step(i % 2 == 0, i % 2 == 0, 0, 0);
      ncmp++;
      if (obs !== exp_v()) begin
        nfail++;
        $display("FAIL tie c%0d got %h want %h", i, obs, exp_v());
      end
    end
    ncmp++;
    if (winner !== 1'b1) begin
      nfail++;
      $display("FAIL tie_winner got %b want 1", winner);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, i == 1 || i == 3 || i == 6, i == 3);
      ncmp++;
      if (obs !== exp_v()) begin
        nfail++;
        $display("FAIL restart c%0d got %h want %h", i, obs, exp_v());
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 10; i++) step(i % 2 == 0, 0, 0, 0);
    step(0, 0, 1, 0);
    ncmp++;
    if (over !== 1'b1) begin
      nfail++;
      $display("FAIL async_pre got %b want 1", over);
    end
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    ncmp++;
    if (obs !== exp_v()) begin
      nfail++;
      $display("FAIL async_reset got %h want %h", obs, exp_v());
    end
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 1, 0);
    ncmp++;
    if (obs !== exp_v()) begin
      nfail++;
      $display("FAIL async_after got %h want %h", obs, exp_v());
    end
  endtask

  task automatic test_random();
    bit gp = 0, ge = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) gp = ~gp;
      if ($urandom_range(0, 3) == 0) ge = ~ge;
      step(gp, ge, $urandom_range(0, 5) == 0,
           $urandom_range(0, 60) == 0);
      ncmp++;
      if (obs !== exp_v()) begin
        nfail++;
        $display("FAIL random c%0d got %h want %h", i, obs, exp_v());
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single_goal();
    test_held_level();
    test_simultaneous();
    test_win_blink_hold();
    test_tie_restart();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
